shift_agc: RTL and testbench
============================

// Module: shift_agc
// PURPOSE
//  Automatic gain (shift) controller for the 40-bit -> 16-bit output shifter.
//  - Watches the 40-bit accumulator stream fed to the shifter, plus the shifter's overflow flag.
//  - Drives the shifter's shift and en inputs.
//  - Fast attack: raises shift as soon as a sample needs it.
//  - Slow decay: lowers shift one step after HOLD consecutive quiet windows.
// PARAMETERS
//  SHIFT_W     5    width of shift output; must match shifter SHIFT_W
//  MAX_SHIFT   24   largest shift ever issued (shifter's top legal case)
//  INIT_SHIFT  0    shift value after reset and while idle
//  WIN_W       8    decay window = 2**WIN_W valid samples
//  HOLD        4    consecutive quiet windows before one decay step (1..15)
// PORTS
//  ck          in   1        clock, all logic on posedge
//  rst_n       in   1        asynchronous reset, active low
//  enable      in   1        1 = run AGC; 0 = return to IDLE
//  freeze      in   1        1 = hold current shift, counters paused
//  in_valid    in   1        in carries a new sample this cycle
//  in          in   40       unsigned accumulator sample (same word the shifter sees)
//  ovf         in   1        overflow flag from shifter (registered there)
//  shift       out  SHIFT_W  shift setting to shifter
//  shift_en    out  1        enable to shifter
//  changed     out  1        one-cycle pulse when shift changes
//  win_peak    out  SHIFT_W  required shift of previous window's peak (status)
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - shift=INIT_SHIFT, shift_en=0, changed=0, win_peak=0.
//   - Window count, hold count and window max cleared; state=IDLE.
//  need(x): combinational, from msb index m of in.
//   - 0 if in[39:16]==0; else min(m-15, MAX_SHIFT). Example: in=2**20 -> need=5.
//  States:
//   - IDLE:   shift_en=0, shift=INIT_SHIFT, counters held at 0. enable=1 -> RUN next cycle.
//   - RUN:    shift_en=1; attack and decay active. freeze=1 -> FROZEN; enable=0 -> IDLE.
//   - FROZEN: shift_en=1; shift, all counters and window max held. freeze=0 -> RUN; enable=0 -> IDLE.
//   - enable=0 has priority over freeze. Entering IDLE restores INIT_SHIFT; changed pulses if shift differed.
//  Attack (RUN only), evaluated each cycle:
//   - tgt_a = need(in) if in_valid, else 0.
//   - tgt_o = shift+1 if ovf, else 0; clamped to MAX_SHIFT.
//   - If max(tgt_a, tgt_o) > shift: shift <= that max on the next edge; hold count cleared.
//   - Latency: one cycle. A sample is shifted with the old value; the next sample uses the new one.
//  Window (RUN only):
//   - Each in_valid increments the window count (WIN_W bits) and updates the window max with need(in).
//   - On the valid that wraps the count to 0, close the window:
//     - win_peak <= final max, including this sample; window max restarts at 0.
//     - If final max < shift and no attack this cycle: hold count +1.
//     - If hold count reaches HOLD: shift <= shift-1, hold count 0.
//     - Otherwise hold count 0.
//  Priority and limits:
//   - Attack always beats decay in the same cycle.
//   - shift never goes below 0 or above MAX_SHIFT.
//   - ovf while shift==MAX_SHIFT is ignored; no wrap-around.
//  changed: registered; 1 for exactly the cycle after any edge on which shift changed value.
//  Reset mid-window or mid-hold discards all partial counts.
// TESTING
//  1. Reset, enable=1, 256 samples of 0x0000_1234 -> shift stays 0, win_peak=0, changed never pulses.
//  2. RUN at shift=0, one sample in=0x00_0010_0000 -> shift=5 next cycle, changed=1 for one cycle.
//  3. shift=5, ovf=1 together with in_valid, need=3 -> shift=6; ovf at shift=24 -> stays 24.
//  4. shift=6, 4 windows of 256 samples with need<=2 -> shift=5 on the 1024th valid;
//     a need=7 sample in window 3 instead -> shift=7, hold count restarts.
//  5. freeze=1 for 1000 valids with large in -> shift unchanged; freeze=0 -> attack resumes next valid.
//  6. rst_n low mid-window with shift=9 -> outputs at reset values immediately, without waiting for ck;
//     enable=0 in RUN with shift=9 -> IDLE, shift=0, shift_en=0, changed pulses.

Source files
------------

// File: rtl/shift_agc.sv
// Automatic gain (shift) controller for the 40-bit -> 16-bit output shifter.
// Fast attack on any sample or overflow needing more headroom, slow windowed decay.
module shift_agc #(
    parameter int SHIFT_W    = 5,
    parameter int MAX_SHIFT  = 24,
    parameter int INIT_SHIFT = 0,
    parameter int WIN_W      = 8,
    parameter int HOLD       = 4
) (
    input  logic               ck,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               freeze,
    input  logic               in_valid,
    input  logic [39:0]        in,
    input  logic               ovf,
    output logic [SHIFT_W-1:0] shift,
    output logic               shift_en,
    output logic               changed,
    output logic [SHIFT_W-1:0] win_peak
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [SHIFT_W-1:0] shift_reg, shift_next;
    logic [SHIFT_W-1:0] peak_reg, peak_next;
    logic [SHIFT_W-1:0] wmax_reg, wmax_next;
    logic [WIN_W-1:0]   wcnt_reg, wcnt_next;
    logic [3:0]         hold_reg, hold_next;
    logic               changed_reg;

    logic [6:0]         need_wide;
    logic [SHIFT_W-1:0] need;
    logic [SHIFT_W:0]   shift_p1;
    logic [SHIFT_W-1:0] tgt_a, tgt_o, tgt, final_max;
    logic               atk;

    // need(): bits above bit 15 that are occupied, capped at the shifter's top case
    always_comb begin
        need_wide = '0;
        for (int i = 16; i < 40; i++) begin
            if (in[i]) need_wide = 7'(i - 15);
        end
        if (need_wide > 7'(MAX_SHIFT)) need_wide = 7'(MAX_SHIFT);
    end
    assign need = need_wide[SHIFT_W-1:0];

    always_comb begin
        shift_p1 = {1'b0, shift_reg} + 1'b1;
        tgt_a    = in_valid ? need : '0;
        tgt_o    = '0;
        if (ovf) begin
            tgt_o = (shift_p1 > (SHIFT_W+1)'(MAX_SHIFT)) ? SHIFT_W'(MAX_SHIFT)
                                                         : shift_p1[SHIFT_W-1:0];
        end
        tgt       = (tgt_a > tgt_o) ? tgt_a : tgt_o;
        atk       = (tgt > shift_reg);
        final_max = (need > wmax_reg) ? need : wmax_reg;
    end

    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        peak_next  = peak_reg;
        wmax_next  = wmax_reg;
        wcnt_next  = wcnt_reg;
        hold_next  = hold_reg;
        case (state_reg)
            IDLE: begin
                shift_next = SHIFT_W'(INIT_SHIFT);
                wcnt_next  = '0;
                wmax_next  = '0;
                hold_next  = '0;
                if (enable) state_next = RUN;
            end
            RUN, FROZEN: begin
                if (!enable) begin
                    state_next = IDLE;
                    shift_next = SHIFT_W'(INIT_SHIFT);
                    wcnt_next  = '0;
                    wmax_next  = '0;
                    hold_next  = '0;
                end else if (freeze) begin
                    // freeze takes hold on the cycle it is seen, so no update slips through
                    state_next = FROZEN;
                end else begin
                    state_next = RUN;
                    if (atk) begin
                        shift_next = tgt;
                        hold_next  = '0;
                    end
                    if (in_valid) begin
                        wcnt_next = wcnt_reg + 1'b1;
                        if (wcnt_reg == '1) begin
                            peak_next = final_max;
                            wmax_next = '0;
                            if (!atk) begin
                                if (final_max < shift_reg) begin
                                    if (hold_reg == 4'(HOLD - 1)) begin
                                        shift_next = shift_reg - 1'b1;
                                        hold_next  = '0;
                                    end else begin
                                        hold_next = hold_reg + 1'b1;
                                    end
                                end else begin
                                    hold_next = '0;
                                end
                            end
                        end else begin
                            wmax_next = final_max;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            shift_reg   <= SHIFT_W'(INIT_SHIFT);
            peak_reg    <= '0;
            wmax_reg    <= '0;
            wcnt_reg    <= '0;
            hold_reg    <= '0;
            changed_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            peak_reg    <= peak_next;
            wmax_reg    <= wmax_next;
            wcnt_reg    <= wcnt_next;
            hold_reg    <= hold_next;
            changed_reg <= (shift_next != shift_reg);
        end
    end

    assign shift    = shift_reg;
    assign shift_en = (state_reg != IDLE);
    assign changed  = changed_reg;
    assign win_peak = peak_reg;

endmodule

// File: tb/tb_shift_agc.sv
// Bench for shift_agc: need() vector table, scoreboard against a behavioural
// model every cycle, and hand-written attack/decay/freeze/reset sequences.
module tb_shift_agc;

    localparam int MAXS = 24;
    localparam int HOLD = 4;
    localparam int WIN  = 256;

    logic        ck = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        freeze = 1'b0;
    logic        in_valid = 1'b0;
    logic [39:0] in = '0;
    logic        ovf = 1'b0;
    logic [4:0]  shift, win_peak;
    logic        shift_en, changed;

    shift_agc dut (
        .ck(ck), .rst_n(rst_n), .enable(enable), .freeze(freeze),
        .in_valid(in_valid), .in(in), .ovf(ovf),
        .shift(shift), .shift_en(shift_en), .changed(changed), .win_peak(win_peak)
    );

    always #5 ck = ~ck;

    int total = 0;
    int bad   = 0;

    // behavioural model state: 0 idle, 1 run, 2 frozen
    int m_state, m_shift, m_peak, m_wcnt, m_wmax, m_hold;
    bit m_chg;

    typedef struct {
        int shift;
        bit en;
        bit chg;
        int peak;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [39:0] x;
        bit          o;
        int          want;
    } vec_t;
    vec_t vt[10];

    task automatic check(input string name, input longint act, input longint want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic int need_f(input logic [39:0] x);
        int r;
        r = 0;
        for (int b = 39; b >= 16; b--) begin
            if (x[b]) begin
                r = b - 15;
                break;
            end
        end
        if (r > MAXS) r = MAXS;
        return r;
    endfunction

    task automatic model_reset();
        m_state = 0; m_shift = 0; m_peak = 0;
        m_wcnt = 0; m_wmax = 0; m_hold = 0; m_chg = 0;
    endtask

    task automatic model_step();
        int old, ns, ta, to, t, fm;
        bit atk;
        old = m_shift;
        ns  = m_shift;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (!enable) begin
            m_state = 0; ns = 0; m_wcnt = 0; m_wmax = 0; m_hold = 0;
        end else if (m_state == 0) begin
            m_state = 1;
        end else if (freeze) begin
            m_state = 2;
        end else begin
            m_state = 1;
            ta = in_valid ? need_f(in) : 0;
            to = 0;
            if (ovf) to = (m_shift + 1 > MAXS) ? MAXS : m_shift + 1;
            t   = (ta > to) ? ta : to;
            atk = (t > m_shift);
            if (atk) begin
                ns = t;
                m_hold = 0;
            end
            if (in_valid) begin
                fm = (need_f(in) > m_wmax) ? need_f(in) : m_wmax;
                m_wcnt++;
                if (m_wcnt == WIN) begin
                    m_wcnt = 0; m_peak = fm; m_wmax = 0;
                    if (!atk) begin
                        if (fm < m_shift) begin
                            m_hold++;
                            if (m_hold == HOLD) begin
                                ns = m_shift - 1;
                                m_hold = 0;
                            end
                        end else begin
                            m_hold = 0;
                        end
                    end
                end else begin
                    m_wmax = fm;
                end
            end
        end
        m_chg   = (ns != old);
        m_shift = ns;
    endtask

    // one clock: predict, push, clock, pop and compare
    task automatic step();
        exp_t e;
        model_step();
        e.shift = m_shift; e.en = (m_state != 0); e.chg = m_chg; e.peak = m_peak;
        sb.push_back(e);
        @(posedge ck);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check("sb_shift", shift, e.shift);
            check("sb_shift_en", shift_en, e.en);
            check("sb_changed", changed, e.chg);
            check("sb_win_peak", win_peak, e.peak);
        end
    endtask

    task automatic drive(input bit v, input logic [39:0] x, input bit o);
        in_valid = v; in = x; ovf = o;
        step();
        in_valid = 1'b0; ovf = 1'b0;
    endtask

    task automatic reenter();
        enable = 1'b0; step();
        enable = 1'b1; step();
    endtask

    task automatic quiet(input int n);
        for (int k = 0; k < n; k++) begin
            if (k % 97 == 50) drive(1'b0, 40'h80_0000_0000, 1'b0);
            drive(1'b1, 40'h00_0002_1234, 1'b0);
        end
    endtask

    initial begin
        vt[0] = '{40'h00_0000_1234, 1'b0, 0};
        vt[1] = '{40'h00_0000_FFFF, 1'b0, 0};
        vt[2] = '{40'h00_0001_0000, 1'b0, 1};
        vt[3] = '{40'h00_0003_0001, 1'b0, 2};
        vt[4] = '{40'h00_0010_0000, 1'b0, 5};
        vt[5] = '{40'h00_8000_0000, 1'b0, 16};
        vt[6] = '{40'h80_0000_0000, 1'b0, 24};
        vt[7] = '{40'hFF_FFFF_FFFF, 1'b0, 24};
        vt[8] = '{40'h00_0000_0001, 1'b1, 1};
        vt[9] = '{40'h00_0010_0000, 1'b1, 5};

        model_reset();
        @(posedge ck); #1;
        @(posedge ck); #1;
        check("reset_shift", shift, 0);
        check("reset_shift_en", shift_en, 0);
        check("reset_changed", changed, 0);
        check("reset_win_peak", win_peak, 0);
        $display("reset: shift=%0d shift_en=%0d", shift, shift_en);
        rst_n = 1'b1;

        // need() table: each vector applied from a fresh RUN entry at shift 0
        for (int i = 0; i < 10; i++) begin
            reenter();
            drive(1'b1, vt[i].x, vt[i].o);
            check("table_shift", shift, vt[i].want);
            check("table_changed", changed, (vt[i].want != 0));
            $display("vec %0d: in=%h ovf=%0d shift=%0d", i, vt[i].x, vt[i].o, shift);
        end

        // a full window of small samples never moves shift
        reenter();
        for (int k = 0; k < WIN; k++) begin
            drive(1'b1, 40'h00_0000_1234, 1'b0);
            check("small_changed", changed, 0);
        end
        check("small_shift", shift, 0);
        check("small_peak", win_peak, 0);
        $display("small window: shift=%0d win_peak=%0d", shift, win_peak);

        // attack, ovf step, ovf at the top is ignored
        reenter();
        drive(1'b1, 40'h00_0010_0000, 1'b0);
        check("atk5_shift", shift, 5);
        drive(1'b0, 40'h0, 1'b0);
        check("atk5_changed_drop", changed, 0);
        drive(1'b1, 40'h00_0004_0000, 1'b1);
        check("ovf6_shift", shift, 6);
        drive(1'b1, 40'h80_0000_0000, 1'b0);
        check("atk24_shift", shift, 24);
        drive(1'b0, 40'h0, 1'b1);
        check("ovf_top_shift", shift, 24);
        check("ovf_top_changed", changed, 0);
        $display("attack/ovf: shift=%0d", shift);

        // decay: four quiet windows after an aligned window
        reenter();
        drive(1'b1, 40'h00_0020_0000, 1'b0);
        check("dec_atk_shift", shift, 6);
        quiet(WIN - 1);
        quiet(4 * WIN - 1);
        check("dec_before", shift, 6);
        drive(1'b1, 40'h00_0002_1234, 1'b0);
        check("dec_after", shift, 5);
        check("dec_changed", changed, 1);
        check("dec_peak", win_peak, 2);
        $display("decay: shift=%0d win_peak=%0d", shift, win_peak);

        // attack inside window 3 restarts the hold count
        reenter();
        drive(1'b1, 40'h00_0020_0000, 1'b0);
        quiet(WIN - 1);
        quiet(2 * WIN);
        drive(1'b1, 40'h00_0040_0000, 1'b0);
        check("restart_atk", shift, 7);
        quiet(WIN - 1);
        quiet(4 * WIN - 1);
        check("restart_before", shift, 7);
        drive(1'b1, 40'h00_0002_1234, 1'b0);
        check("restart_after", shift, 6);
        $display("hold restart: shift=%0d", shift);

        // freeze holds shift against large samples and overflow
        freeze = 1'b1;
        for (int k = 0; k < 1000; k++) drive(1'b1, 40'h80_0000_0000, 1'b1);
        check("frz_shift", shift, 6);
        check("frz_en", shift_en, 1);
        freeze = 1'b0;
        drive(1'b0, 40'h0, 1'b0);
        check("unfrz_idle", shift, 6);
        drive(1'b1, 40'h80_0000_0000, 1'b0);
        check("unfrz_atk", shift, 24);
        $display("freeze: shift=%0d", shift);

        // asynchronous reset mid-window
        reenter();
        drive(1'b1, 40'h00_0100_0000, 1'b0);
        check("pre_rst_shift", shift, 9);
        quiet(100);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_shift", shift, 0);
        check("arst_en", shift_en, 0);
        check("arst_changed", changed, 0);
        check("arst_peak", win_peak, 0);
        $display("async reset: shift=%0d shift_en=%0d", shift, shift_en);
        model_reset();
        sb.delete();
        step();
        rst_n = 1'b1;
        step();
        quiet(WIN - 1);
        check("post_rst_peak", win_peak, 0);
        drive(1'b1, 40'h00_0000_0001, 1'b0);
        check("post_rst_peak2", win_peak, 2);

        // disable from RUN returns to IDLE with a change pulse
        reenter();
        drive(1'b1, 40'h00_0100_0000, 1'b0);
        enable = 1'b0;
        step();
        check("dis_shift", shift, 0);
        check("dis_en", shift_en, 0);
        check("dis_changed", changed, 1);
        step();
        check("dis_changed_drop", changed, 0);
        $display("disable: shift=%0d shift_en=%0d", shift, shift_en);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
